// File: rtl/csi_pkt_ctrl_pkg.sv
// Shared types and constants for the CSI-2 packet controller: FSM states,
// data-type codes and the header ECC syndrome table.
package csi_pkt_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_DROP
  } state_t;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_RAW8      = 6'h2A;
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  localparam logic [15:0] CRC_BYTES = 16'd2;

  // Parity column for each of the 24 header data bits, entry 23 leftmost.
  localparam logic [23:0][5:0] SYND_TBL = {
    6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
  };

endpackage

// File: rtl/csi_pkt_ctrl_hdr_ecc.sv
// Combinational CSI-2 packet-header ECC generator (24-bit header -> 8-bit ECC,
// upper two bits always zero).
module hdr_ecc
  import csi_pkt_ctrl_pkg::*;
(
  input  logic [23:0] data,
  output logic [7:0]  ecc
);

  always_comb begin
    ecc = '0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (data[i]) ecc[5:0] = ecc[5:0] ^ SYND_TBL[i];
    end
  end

endmodule

// File: rtl/csi_pkt_ctrl.sv
// CSI-2 packet controller: header parse/ECC check, payload forwarding, error
// counting. Define CSI_ECC_CORR_EN to enable single-bit header ECC correction.
module csi_pkt_ctrl
  import csi_pkt_ctrl_pkg::*;
#(
  parameter logic [1:0]  VC_SEL = 2'd0,
  parameter logic [15:0] MAX_WC = 16'd4096
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_vld,
  input  logic       byte_sot,
  output logic       frame_start,
  output logic       frame_end,
  output logic       line_start,
  output logic       line_end,
  output logic [7:0] pay_data,
  output logic       pay_vld,
  output logic       pay_last,
  output logic [5:0] pay_dt,
  output logic       ecc_err,
  output logic       ecc_corr,
  output logic       trunc_err,
  output logic [15:0] err_cnt,
  output logic       busy
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  di_q, di_d, wcl_q, wcl_d, wcm_q, wcm_d;
  logic [15:0] cnt_q, cnt_d, err_q, err_d;
  logic [5:0]  pay_dt_q, pay_dt_d;
  logic [7:0]  pay_data_q, pay_data_d;
  logic        pay_vld_q, pay_vld_d, pay_last_q, pay_last_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic        ecc_err_q, ecc_err_d, ecc_corr_q, ecc_corr_d, trunc_q, trunc_d;
  logic        err_inc;

  logic [23:0] ph_data, fix_data;
  logic [7:0]  ecc_calc, synd;
  logic        corr, unc, hdr_bad;
  logic [1:0]  fix_vc;
  logic [5:0]  fix_dt;
  logic [15:0] fix_wc;

  assign ph_data = {wcm_q, wcl_q, di_q};

  hdr_ecc u_hdr_ecc (
    .data (ph_data),
    .ecc  (ecc_calc)
  );

  // ecc_calc[7:6] is always zero, so synd[7:6] is the received reserved field.
  assign synd = byte_data ^ ecc_calc;

`ifdef CSI_ECC_CORR_EN
  logic col_hit;

  always_comb begin
    fix_data = ph_data;
    col_hit  = 1'b0;
    corr     = 1'b0;
    unc      = 1'b0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (synd[5:0] == SYND_TBL[i]) begin
        fix_data[i] = ~ph_data[i];
        col_hit     = 1'b1;
      end
    end
    // A lone syndrome bit means the ECC byte itself took the hit.
    if (synd[5:0] != 6'd0) begin
      if (col_hit || ((synd[5:0] & (synd[5:0] - 6'd1)) == 6'd0)) corr = 1'b1;
      else                                                       unc  = 1'b1;
    end
  end
`else
  always_comb begin
    fix_data = ph_data;
    corr     = 1'b0;
    unc      = (synd[5:0] != 6'd0);
  end
`endif

  assign hdr_bad = unc | (synd[7:6] != 2'd0);
  assign fix_vc  = fix_data[7:6];
  assign fix_dt  = fix_data[5:0];
  assign fix_wc  = fix_data[23:8];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    di_d       = di_q;
    wcl_d      = wcl_q;
    wcm_d      = wcm_q;
    cnt_d      = cnt_q;
    pay_dt_d   = pay_dt_q;
    pay_data_d = pay_data_q;
    pay_vld_d  = 1'b0;
    pay_last_d = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    ls_d       = 1'b0;
    le_d       = 1'b0;
    ecc_err_d  = 1'b0;
    ecc_corr_d = 1'b0;
    trunc_d    = 1'b0;
    err_inc    = 1'b0;

    if (byte_vld && byte_sot) begin
      if (state_q inside {ST_HDR, ST_PAYLOAD, ST_CRC}) begin
        trunc_d = 1'b1;
        err_inc = 1'b1;
      end
      state_d = ST_HDR;
      di_d    = byte_data;
      idx_d   = '0;
    end else if (byte_vld) begin
      unique case (state_q)
        ST_HDR: begin
          unique case (idx_q)
            2'd0: begin wcl_d = byte_data; idx_d = 2'd1; end
            2'd1: begin wcm_d = byte_data; idx_d = 2'd2; end
            default: begin
              idx_d = '0;
              if (hdr_bad) begin
                ecc_err_d = 1'b1;
                err_inc   = 1'b1;
                state_d   = ST_DROP;
              end else begin
                ecc_corr_d = corr;
                if (fix_vc != VC_SEL) begin
                  state_d = ST_DROP;
                end else if (fix_dt <= DT_SHORT_MAX) begin
                  fs_d    = (fix_dt == DT_FS);
                  fe_d    = (fix_dt == DT_FE);
                  ls_d    = (fix_dt == DT_LS);
                  le_d    = (fix_dt == DT_LE);
                  state_d = ST_IDLE;
                end else if (fix_wc > MAX_WC) begin
                  ecc_err_d = 1'b1;
                  err_inc   = 1'b1;
                  state_d   = ST_DROP;
                end else if (fix_wc == 16'd0) begin
                  cnt_d   = CRC_BYTES;
                  state_d = ST_CRC;
                end else begin
                  cnt_d    = fix_wc;
                  pay_dt_d = fix_dt;
                  state_d  = ST_PAYLOAD;
                end
              end
            end
          endcase
        end
        ST_PAYLOAD: begin
          pay_data_d = byte_data;
          pay_vld_d  = 1'b1;
          pay_last_d = (cnt_q == 16'd1);
          cnt_d      = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            cnt_d   = CRC_BYTES;
            state_d = ST_CRC;
          end
        end
        ST_CRC: begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end

    err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      di_q       <= '0;
      wcl_q      <= '0;
      wcm_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      pay_dt_q   <= '0;
      pay_data_q <= '0;
      pay_vld_q  <= 1'b0;
      pay_last_q <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      ls_q       <= 1'b0;
      le_q       <= 1'b0;
      ecc_err_q  <= 1'b0;
      ecc_corr_q <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      di_q       <= di_d;
      wcl_q      <= wcl_d;
      wcm_q      <= wcm_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      pay_dt_q   <= pay_dt_d;
      pay_data_q <= pay_data_d;
      pay_vld_q  <= pay_vld_d;
      pay_last_q <= pay_last_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      ls_q       <= ls_d;
      le_q       <= le_d;
      ecc_err_q  <= ecc_err_d;
      ecc_corr_q <= ecc_corr_d;
      trunc_q    <= trunc_d;
    end
  end

  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign line_start  = ls_q;
  assign line_end    = le_q;
  assign pay_data    = pay_data_q;
  assign pay_vld     = pay_vld_q;
  assign pay_last    = pay_last_q;
  assign pay_dt      = pay_dt_q;
  assign ecc_err     = ecc_err_q;
  assign ecc_corr    = ecc_corr_q;
  assign trunc_err   = trunc_q;
  assign err_cnt     = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csi_pkt_ctrl.sv
// Directed bench for csi_pkt_ctrl; expectations adapt to CSI_ECC_CORR_EN.
module tb_csi_pkt_ctrl;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic [7:0]  byte_data;
  logic        byte_vld;
  logic        byte_sot;
  logic        frame_start, frame_end, line_start, line_end;
  logic [7:0]  pay_data;
  logic        pay_vld, pay_last;
  logic [5:0]  pay_dt;
  logic        ecc_err, ecc_corr, trunc_err;
  logic [15:0] err_cnt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_err;

  csi_pkt_ctrl #(.VC_SEL(2'd0), .MAX_WC(16'd4096)) dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .byte_data   (byte_data),
    .byte_vld    (byte_vld),
    .byte_sot    (byte_sot),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_start  (line_start),
    .line_end    (line_end),
    .pay_data    (pay_data),
    .pay_vld     (pay_vld),
    .pay_last    (pay_last),
    .pay_dt      (pay_dt),
    .ecc_err     (ecc_err),
    .ecc_corr    (ecc_corr),
    .trunc_err   (trunc_err),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one byte before a rising edge; returns at the next falling edge,
  // where outputs registered from that byte are visible.
  task automatic send(input logic [7:0] b, input logic sot);
    byte_data = b;
    byte_vld  = 1'b1;
    byte_sot  = sot;
    @(negedge sclk);
  endtask

  task automatic gap();
    byte_vld = 1'b0;
    byte_sot = 1'b0;
    @(negedge sclk);
  endtask

  task automatic hdr(input logic [7:0] di, input logic [7:0] wl, input logic [7:0] wm,
                     input logic [7:0] ecc);
    send(di, 1'b1);
    send(wl, 1'b0);
    send(wm, 1'b0);
    send(ecc, 1'b0);
  endtask

  initial begin
    s_rst_n   = 1'b0;
    byte_data = '0;
    byte_vld  = 1'b0;
    byte_sot  = 1'b0;
    exp_err   = 16'd0;
    @(negedge sclk);
    @(negedge sclk);
    check("rst_busy", busy, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_pay_vld", pay_vld, 0);
    check("rst_fs", frame_start, 0);
    s_rst_n = 1'b1;
    @(negedge sclk);

    send(8'h55, 1'b0);
    check("no_sot_ignored", busy, 0);

    // Frame start, then pulse must be one cycle wide
    hdr(8'h00, 8'h01, 8'h00, 8'h1A);
    check("fs_pulse", frame_start, 1);
    check("fs_idle", busy, 0);
    check("fs_no_err", ecc_err, 0);
    check("fs_err_cnt", err_cnt, 0);
    gap();
    check("fs_one_cycle", frame_start, 0);

    hdr(8'h01, 8'h01, 8'h00, 8'h1D);
    check("fe_pulse", frame_end, 1);
    check("fe_not_fs", frame_start, 0);
    hdr(8'h03, 8'h01, 8'h00, 8'h16);
    check("le_pulse", line_end, 1);
    check("le_not_ls", line_start, 0);

    // RAW8 long packet, WC=4, with a gap inside the payload
    hdr(8'h2A, 8'h04, 8'h00, 8'h33);
    check("lp_busy", busy, 1);
    check("lp_hdr_novld", pay_vld, 0);
    send(8'hDA, 1'b0);
    check("lp_vld0", pay_vld, 1);
    check("lp_data0", pay_data, 8'hDA);
    check("lp_last0", pay_last, 0);
    check("lp_dt", pay_dt, 6'h2A);
    send(8'hDB, 1'b0);
    check("lp_data1", pay_data, 8'hDB);
    gap();
    check("lp_gap_novld", pay_vld, 0);
    send(8'hDC, 1'b0);
    check("lp_data2", pay_data, 8'hDC);
    check("lp_last2", pay_last, 0);
    send(8'hDD, 1'b0);
    check("lp_data3", pay_data, 8'hDD);
    check("lp_last3", pay_last, 1);
    send(8'hC0, 1'b0);
    check("lp_crc_novld", pay_vld, 0);
    check("lp_crc_busy", busy, 1);
    send(8'hC1, 1'b0);
    check("lp_crc_done", busy, 0);

    // Single data-bit error in DI (bit 0)
    hdr(8'h01, 8'h01, 8'h00, 8'h1A);
`ifdef CSI_ECC_CORR_EN
    check("corr_fs", frame_start, 1);
    check("corr_pulse", ecc_corr, 1);
    check("corr_no_err", ecc_err, 0);
`else
    exp_err = exp_err + 16'd1;
    check("nocorr_err", ecc_err, 1);
    check("nocorr_fs", frame_start, 0);
    check("nocorr_corr", ecc_corr, 0);
`endif
    check("bit0_fe", frame_end, 0);
    check("bit0_err_cnt", err_cnt, exp_err);

    // Reserved ECC bit set: error in both builds, then drop until sot
    hdr(8'h00, 8'h01, 8'h00, 8'h5A);
    exp_err = exp_err + 16'd1;
    check("rsvd_err", ecc_err, 1);
    check("rsvd_err_cnt", err_cnt, exp_err);
    check("rsvd_drop", busy, 1);
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h1A, 1'b0);
    check("drop_no_fs", frame_start, 0);
    check("drop_busy", busy, 1);
    hdr(8'h00, 8'h01, 8'h00, 8'h1A);
    check("drop_restart_fs", frame_start, 1);
    check("drop_restart_noerr", err_cnt, exp_err);

    // Wrong virtual channel: silent drop
    hdr(8'h40, 8'h01, 8'h00, 8'h0C);
    check("vc_no_fs", frame_start, 0);
    check("vc_no_err", ecc_err, 0);
    check("vc_drop", busy, 1);
    check("vc_err_cnt", err_cnt, exp_err);

    // WC = MAX_WC + 1 is an error
    hdr(8'h2A, 8'h01, 8'h10, 8'h15);
    exp_err = exp_err + 16'd1;
    check("wc_big_err", ecc_err, 1);
    check("wc_big_cnt", err_cnt, exp_err);

    // WC = MAX_WC accepted, then truncated by a new header
    hdr(8'h2A, 8'h00, 8'h10, 8'h0F);
    check("wc_max_ok", ecc_err, 0);
    send(8'h77, 1'b0);
    check("wc_max_vld", pay_vld, 1);
    check("wc_max_last", pay_last, 0);
    send(8'h2A, 1'b1);
    exp_err = exp_err + 16'd1;
    check("pl_trunc", trunc_err, 1);
    check("pl_trunc_cnt", err_cnt, exp_err);

    // That restart byte is DI of a WC=0 packet -> straight to CRC
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h10, 1'b0);
    check("wc0_novld", pay_vld, 0);
    check("wc0_busy", busy, 1);
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    check("wc0_done", busy, 0);

    // sot on the 3rd payload byte
    hdr(8'h2A, 8'h04, 8'h00, 8'h33);
    send(8'hDA, 1'b0);
    send(8'hDB, 1'b0);
    send(8'h00, 1'b1);
    exp_err = exp_err + 16'd1;
    check("tr_pulse", trunc_err, 1);
    check("tr_no_vld", pay_vld, 0);
    check("tr_no_last", pay_last, 0);
    check("tr_cnt", err_cnt, exp_err);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h1A, 1'b0);
    check("tr_new_hdr_fs", frame_start, 1);

    // Asynchronous reset mid-payload
    hdr(8'h2A, 8'h04, 8'h00, 8'h33);
    send(8'hDA, 1'b0);
    check("mr_vld_before", pay_vld, 1);
    s_rst_n = 1'b0;
    #1;
    check("mr_vld", pay_vld, 0);
    check("mr_busy", busy, 0);
    check("mr_err_cnt", err_cnt, 0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    send(8'hDB, 1'b0);
    check("mr_ignore_vld", pay_vld, 0);
    check("mr_ignore_busy", busy, 0);

    // Back-to-back sot bytes: one truncation error per byte after the first
    for (int i = 0; i < 65535; i++) send(8'h00, 1'b1);
    check("sat_fffe", err_cnt, 16'hFFFE);
    send(8'h00, 1'b1);
    check("sat_ffff", err_cnt, 16'hFFFF);
    send(8'h00, 1'b1);
    check("sat_hold", err_cnt, 16'hFFFF);
    check("sat_trunc", trunc_err, 1);
    gap();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
